// File: rtl/klingon_pkg.sv
// rtl/klingon_pkg.sv - Klingon numeral glyph table and segment constants
package klingon_pkg;

    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Entry 15 first; codes 10-15 render as a dash.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
        7'b1101110,   // 9
        7'b0111001,   // 8
        7'b1110000,   // 7
        7'b0011011,   // 6
        7'b1100011,   // 5
        7'b0101101,   // 4
        7'b1010010,   // 3
        7'b1001001,   // 2
        7'b0000110,   // 1
        7'b0110110    // 0
    };

endpackage

// File: rtl/klingon_glyph.sv
// rtl/klingon_glyph.sv - combinational nibble to Klingon seven-segment decode
module klingon_glyph
    import klingon_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = GLYPH_TABLE[nib];

endmodule

// File: rtl/klingon_scan_display.sv
// rtl/klingon_scan_display.sv - multiplexed Klingon digit scanner; KLINGON_LZ_BLANK_EN adds leading-zero blanking
module klingon_scan_display
    import klingon_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIV_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [DIGITS-1:0][3:0]  disp;
    logic                    tc;
    logic                    last_digit;
    logic [3:0]              cur_nib;
    logic [6:0]              glyph_seg;
    logic                    suppress;

    assign tc         = &cnt;
    assign last_digit = (idx == IDX_W'(DIGITS - 1));
    assign cur_nib    = disp[idx];

    klingon_glyph u_glyph (
        .nib (cur_nib),
        .seg (glyph_seg)
    );

`ifdef KLINGON_LZ_BLANK_EN
    // A digit is suppressed when it and every digit above it are zero.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        suppress   = 1'b0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero && (disp[k] == 4'd0);
            if (idx == IDX_W'(k))
                suppress = upper_zero;
        end
    end
`else
    assign suppress = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            idx   <= '0;
            disp  <= '0;
            seg   <= SEG_BLANK;
            an    <= '0;
            frame <= 1'b0;
        end else begin
            cnt   <= cnt + DIV_W'(1);
            frame <= tc && last_digit;
            if (load)
                disp <= value;
            // The cycle after each terminal count is blanked so the old glyph never lights the new anode.
            if (tc) begin
                idx <= last_digit ? '0 : idx + IDX_W'(1);
                an  <= '0;
                seg <= SEG_BLANK;
            end else if (suppress) begin
                an  <= '0;
                seg <= SEG_BLANK;
            end else begin
                an  <= DIGITS'(1) << idx;
                seg <= glyph_seg;
            end
        end
    end

endmodule
